// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus sequencer: state encoding, init-sequence
// constants and the address/data phase-select values.
package rtc_bus_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_SET = 3'd1;
  localparam logic [2:0] S_A_PUL = 3'd2;
  localparam logic [2:0] S_A_HLD = 3'd3;
  localparam logic [2:0] S_D_SET = 3'd4;
  localparam logic [2:0] S_D_PUL = 3'd5;
  localparam logic [2:0] S_D_HLD = 3'd6;
  localparam logic [2:0] S_RECOV = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_A_SET = S_A_SET,
    ST_A_PUL = S_A_PUL,
    ST_A_HLD = S_A_HLD,
    ST_D_SET = S_D_SET,
    ST_D_PUL = S_D_PUL,
    ST_D_HLD = S_D_HLD,
    ST_RECOV = S_RECOV
  } estado_t;

  localparam logic [7:0] RTC_INIT_ADDR = 8'h02;
  localparam logic [7:0] RTC_INIT_D0   = 8'h10;
  localparam logic [7:0] RTC_INIT_D1   = 8'h00;

  localparam logic DIR_ADDR = 1'b0;
  localparam logic DIR_DATA = 1'b1;

endpackage

// File: rtl/secuenciador_bus_rtc_contador_fase.sv
// Loadable down-counter timing each bus phase; cero_o flags the last cycle
// of the phase currently loaded.
module contador_fase #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         carga_i,
  input  logic [W-1:0] valor_i,
  output logic [W-1:0] cuenta_o,
  output logic         cero_o
);

  logic [W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga_i) begin
      cuenta_d = valor_i;
    end else if (cuenta_q != '0) begin
      cuenta_d = cuenta_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign cuenta_o = cuenta_q;
  assign cero_o   = (cuenta_q == '0);

endmodule

// File: rtl/secuenciador_bus_rtc.sv
// Sequences one multiplexed address/data transaction on the 8-bit RTC bus.
// Optional power-up init writes are enabled with `define RTC_INIT_SEQ_EN.
module secuenciador_bus_rtc
  import rtc_bus_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_HOLD  = 2,
  parameter int T_RECOV = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  input  logic [7:0] in_reg_dato,
  output logic       out_flag_dato,
  output logic       out_direccion_dato,
  output logic       out_controlador_dato,
  output logic [7:0] out_addr,
  output logic [7:0] out_dato,
  output logic       out_flag_inicio,
  output logic       cs_n,
  output logic       a_d,
  output logic       rd_n,
  output logic       wr_n
);

  localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX_HR = (T_HOLD > T_RECOV) ? T_HOLD : T_RECOV;
  localparam int T_MAX    = (T_MAX_SP > T_MAX_HR) ? T_MAX_SP : T_MAX_HR;
  localparam int CW       = $clog2(T_MAX + 1);

  // Counter holds cycles remaining after the current one, so load T-1.
  function automatic logic [CW-1:0] duracion(input estado_t s);
    case (s)
      ST_A_SET, ST_D_SET: duracion = CW'(T_SETUP - 1);
      ST_A_PUL, ST_D_PUL: duracion = CW'(T_PULSE - 1);
      ST_A_HLD, ST_D_HLD: duracion = CW'(T_HOLD - 1);
      ST_RECOV:           duracion = CW'(T_RECOV - 1);
      default:            duracion = '0;
    endcase
  endfunction

  function automatic estado_t siguiente(input estado_t s);
    case (s)
      ST_A_SET: siguiente = ST_A_PUL;
      ST_A_PUL: siguiente = ST_A_HLD;
      ST_A_HLD: siguiente = ST_D_SET;
      ST_D_SET: siguiente = ST_D_PUL;
      ST_D_PUL: siguiente = ST_D_HLD;
      ST_D_HLD: siguiente = ST_RECOV;
      default:  siguiente = ST_IDLE;
    endcase
  endfunction

  estado_t       state_q, state_d;
  logic          rw_q, rw_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          init_txn_q, init_txn_d;
  logic [7:0]    rdata_q;
  logic          busy_q, done_q;
  logic          cs_n_q, a_d_q, rd_n_q, wr_n_q;
  logic          flag_dato_q, dir_q, ctrl_q;

  logic          cnt_load;
  logic [CW-1:0] cnt_val, cnt_q;
  logic          cnt_zero;
  logic          can_start, start_init, start_user;
  logic          init_pending, init_pending_d;
  logic [7:0]    init_dato;
  logic          last_d, addr_ph_d, data_ph_d;

`ifdef RTC_INIT_SEQ_EN
  logic [1:0] init_cnt_q, init_cnt_d;
  logic       flag_inicio_q;

  assign init_pending   = (init_cnt_q != 2'd0);
  assign init_cnt_d     = start_init ? (init_cnt_q - 2'd1) : init_cnt_q;
  assign init_pending_d = (init_cnt_d != 2'd0);
  assign init_dato      = (init_cnt_q == 2'd2) ? RTC_INIT_D0 : RTC_INIT_D1;
  assign out_flag_inicio = flag_inicio_q;
`else
  assign init_pending    = 1'b0;
  assign init_pending_d  = 1'b0;
  assign init_dato       = RTC_INIT_D0;
  assign out_flag_inicio = 1'b0;
`endif

  contador_fase #(.W(CW)) u_contador (
    .clk_i    (clk),
    .rst_i    (reset),
    .carga_i  (cnt_load),
    .valor_i  (cnt_val),
    .cuenta_o (cnt_q),
    .cero_o   (cnt_zero)
  );

  // The last RECOV cycle doubles as an accept point, so back-to-back
  // requests keep cs_n high for exactly T_RECOV cycles.
  always_comb begin
    can_start  = (state_q == ST_IDLE) || ((state_q == ST_RECOV) && cnt_zero);
    start_init = can_start && init_pending;
    start_user = can_start && !init_pending && req;

    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    init_txn_d = init_txn_q;

    if (start_init) begin
      rw_d       = 1'b1;
      addr_d     = RTC_INIT_ADDR;
      wdata_d    = init_dato;
      init_txn_d = 1'b1;
    end else if (start_user) begin
      rw_d       = rw;
      addr_d     = addr;
      wdata_d    = wdata;
      init_txn_d = 1'b0;
    end

    if (start_init || start_user) begin
      state_d  = ST_A_SET;
      cnt_load = 1'b1;
      cnt_val  = duracion(ST_A_SET);
    end else if ((state_q != ST_IDLE) && cnt_zero) begin
      state_d  = siguiente(state_q);
      cnt_load = 1'b1;
      cnt_val  = duracion(state_d);
    end

    last_d    = cnt_load ? (cnt_val == '0) : (cnt_q == CW'(1));
    addr_ph_d = (state_d inside {ST_A_SET, ST_A_PUL, ST_A_HLD});
    data_ph_d = (state_d inside {ST_D_SET, ST_D_PUL, ST_D_HLD});
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      init_txn_q  <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      a_d_q       <= 1'b0;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      flag_dato_q <= 1'b0;
      dir_q       <= DIR_ADDR;
      ctrl_q      <= 1'b0;
`ifdef RTC_INIT_SEQ_EN
      init_cnt_q    <= 2'd2;
      flag_inicio_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      init_txn_q <= init_txn_d;
      if ((state_q == ST_D_PUL) && cnt_zero && !rw_q) begin
        rdata_q <= in_reg_dato;
      end
      busy_q      <= (state_d != ST_IDLE) || init_pending_d;
      done_q      <= (state_d == ST_RECOV) && last_d && !init_txn_d;
      cs_n_q      <= !(addr_ph_d || data_ph_d);
      a_d_q       <= addr_ph_d;
      wr_n_q      <= !((state_d == ST_A_PUL) || ((state_d == ST_D_PUL) && rw_d));
      rd_n_q      <= !((state_d == ST_D_PUL) && !rw_d);
      flag_dato_q <= addr_ph_d || data_ph_d;
      dir_q       <= data_ph_d ? DIR_DATA : DIR_ADDR;
      ctrl_q      <= addr_ph_d || (data_ph_d && rw_d);
`ifdef RTC_INIT_SEQ_EN
      init_cnt_q    <= init_cnt_d;
      flag_inicio_q <= ((state_d != ST_IDLE) && init_txn_d) || init_pending_d;
`endif
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign rdata                = rdata_q;
  assign out_flag_dato        = flag_dato_q;
  assign out_direccion_dato   = dir_q;
  assign out_controlador_dato = ctrl_q;
  assign out_addr             = addr_q;
  assign out_dato             = wdata_q;
  assign cs_n                 = cs_n_q;
  assign a_d                  = a_d_q;
  assign rd_n                 = rd_n_q;
  assign wr_n                 = wr_n_q;

endmodule

// File: tb/tb_secuenciador_bus_rtc.sv
// Self-checking bench for secuenciador_bus_rtc: vector table, cycle model and
// read-data scoreboard, plus back-to-back, ignored-request and reset cases.
module tb_secuenciador_bus_rtc;

  localparam int TS = 2, TP = 4, TH = 2, TR = 3;
  localparam int K_END      = 2 * (TS + TP + TH) + TR;
  localparam int K_DPUL_END = 2 * TS + 2 * TP + TH;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] in_reg_dato = 8'h00;
  logic       busy, done;
  logic [7:0] rdata;
  logic       out_flag_dato, out_direccion_dato, out_controlador_dato;
  logic [7:0] out_addr, out_dato;
  logic       out_flag_inicio;
  logic       cs_n, a_d, rd_n, wr_n;

  secuenciador_bus_rtc #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH), .T_RECOV(TR)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req                  (req),
    .rw                   (rw),
    .addr                 (addr),
    .wdata                (wdata),
    .busy                 (busy),
    .done                 (done),
    .rdata                (rdata),
    .in_reg_dato          (in_reg_dato),
    .out_flag_dato        (out_flag_dato),
    .out_direccion_dato   (out_direccion_dato),
    .out_controlador_dato (out_controlador_dato),
    .out_addr             (out_addr),
    .out_dato             (out_dato),
    .out_flag_inicio      (out_flag_inicio),
    .cs_n                 (cs_n),
    .a_d                  (a_d),
    .rd_n                 (rd_n),
    .wr_n                 (wr_n)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic cs_n, a_d, rd_n, wr_n, busy, done, flag, dir, ctrl;
  } sig_t;

  typedef struct {
    bit         rw;
    logic [7:0] addr, wdata, rdin;
  } vec_t;

  typedef struct {
    logic [7:0] addr, rdata;
  } sb_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  sb_t        cola[$];
  logic [7:0] exp_rd = 8'h00;
  vec_t       tabla[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, req_v, $time);
    end
  endtask

  // Expected pins k cycles after the accept cycle (k=0: idle).
  function automatic sig_t modelo(input int k, input bit rw_m);
    sig_t s;
    int a_pul = TS + 1, a_hld = TS + TP + 1, d_set = TS + TP + TH + 1;
    int d_pul = d_set + TS, d_hld = d_set + TS + TP, rec = d_set + TS + TP + TH;
    bit ap = (k >= 1) && (k < d_set);
    bit dp = (k >= d_set) && (k < rec);
    s.cs_n = !(ap || dp);
    s.a_d  = ap;
    s.wr_n = !(((k >= a_pul) && (k < a_hld)) || (rw_m && (k >= d_pul) && (k < d_hld)));
    s.rd_n = !(!rw_m && (k >= d_pul) && (k < d_hld));
    s.busy = (k >= 1) && (k <= K_END);
    s.done = (k == K_END);
    s.flag = ap || dp;
    s.dir  = dp;
    s.ctrl = ap || (dp && rw_m);
    return s;
  endfunction

  function automatic sig_t actual();
    sig_t s;
    s = {cs_n, a_d, rd_n, wr_n, busy, done, out_flag_dato, out_direccion_dato,
         out_controlador_dato};
    return s;
  endfunction

  task automatic empujar(input bit rw_t, input logic [7:0] addr_t, input logic [7:0] rdin_t);
    sb_t e;
    if (!rw_t) exp_rd = rdin_t;
    e.addr  = addr_t;
    e.rdata = exp_rd;
    cola.push_back(e);
  endtask

  task automatic iniciar(input bit rw_t, input logic [7:0] addr_t, input logic [7:0] wdata_t,
                         input logic [7:0] rdin_t);
    rw = rw_t;
    addr = addr_t;
    wdata = wdata_t;
    req = 1'b1;
    empujar(rw_t, addr_t, rdin_t);
    @(posedge clk); #1;
  endtask

  task automatic cuerpo(input bit rw_t, input logic [7:0] addr_t, input logic [7:0] wdata_t,
                        input logic [7:0] rdin_t, input int abort_k, input bit keep,
                        input bit nrw, input logic [7:0] naddr, input logic [7:0] nwdata,
                        input bit poke);
    sb_t e;
    for (int k = 1; k <= K_END; k++) begin
      if (k == 1 && !keep) req = 1'b0;
      in_reg_dato = (k == K_DPUL_END) ? rdin_t : ~rdin_t;
      chk($sformatf("pins_k%0d_rw%0d", k, rw_t), 32'(actual()), 32'(modelo(k, rw_t)));
      if (k == TS + 2) begin
        chk("out_addr_mid", 32'(out_addr), 32'(addr_t));
        chk("out_dato_mid", 32'(out_dato), 32'(wdata_t));
        if (poke) begin
          req = 1'b1; addr = 8'h99; wdata = 8'h66; rw = ~rw_t;
        end
      end
      if (poke && k == TS + 3) req = 1'b0;
      if (k == abort_k) begin
        reset = 1'b1;
        return;
      end
      if (k == K_END) begin
        if (cola.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_empty: done with no expected entry at %0t", $time);
        end else begin
          e = cola.pop_front();
          chk("rdata_at_done", 32'(rdata), 32'(e.rdata));
          chk("addr_at_done", 32'(out_addr), 32'(e.addr));
        end
        if (keep) begin
          rw = nrw; addr = naddr; wdata = nwdata;
        end
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic esperar_init();
`ifdef RTC_INIT_SEQ_EN
    int         nw;
    logic [7:0] dat[2];
    logic       wr_prev;
    nw = 0; wr_prev = 1'b1; dat[0] = 8'hEE; dat[1] = 8'hEE;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (c > 2 && !busy) break;
      chk("init_no_done", 32'(done), 32'(0));
      chk("init_flag", 32'(out_flag_inicio), 32'(1));
      if (!wr_n && wr_prev && !a_d && !cs_n) begin
        if (nw < 2) dat[nw] = out_dato;
        nw++;
        chk("init_addr", 32'(out_addr), 32'(8'h02));
      end
      wr_prev = wr_n;
    end
    chk("init_writes", 32'(nw), 32'(2));
    chk("init_d0", 32'(dat[0]), 32'(8'h10));
    chk("init_d1", 32'(dat[1]), 32'(8'h00));
    chk("init_idle", 32'(busy), 32'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tabla[0] = '{rw: 1'b1, addr: 8'h21, wdata: 8'h45, rdin: 8'h00};
    tabla[1] = '{rw: 1'b0, addr: 8'h22, wdata: 8'h00, rdin: 8'h37};
    tabla[2] = '{rw: 1'b0, addr: 8'h80, wdata: 8'hC3, rdin: 8'hA5};
    tabla[3] = '{rw: 1'b1, addr: 8'hFF, wdata: 8'h00, rdin: 8'h5A};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", 32'(actual()), 32'(9'b1_0_1_1_0_0_0_0_0));
    chk("reset_rdata", 32'(rdata), 32'(0));
    chk("reset_out_addr", 32'(out_addr), 32'(0));
    chk("reset_out_dato", 32'(out_dato), 32'(0));
    chk("reset_flag_inicio", 32'(out_flag_inicio), 32'(0));
    reset = 1'b0;
    esperar_init();

    for (int i = 0; i < 4; i++) begin
      iniciar(tabla[i].rw, tabla[i].addr, tabla[i].wdata, tabla[i].rdin);
      cuerpo(tabla[i].rw, tabla[i].addr, tabla[i].wdata, tabla[i].rdin, 0, 1'b0,
             1'b0, 8'h00, 8'h00, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("idle_after_vec%0d", i), 32'(actual()), 32'(modelo(0, 1'b0)));
    end

    // Back-to-back writes with req held high.
    iniciar(1'b1, 8'h30, 8'h11, 8'h00);
    cuerpo(1'b1, 8'h30, 8'h11, 8'h00, 0, 1'b1, 1'b1, 8'h31, 8'h22, 1'b0);
    empujar(1'b1, 8'h31, 8'h00);
    @(posedge clk); #1;
    cuerpo(1'b1, 8'h31, 8'h22, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    chk("idle_after_b2b", 32'(actual()), 32'(modelo(0, 1'b0)));

    // Request pulsed in A_PUL with another address must be ignored.
    iniciar(1'b0, 8'h40, 8'h00, 8'h3C);
    cuerpo(1'b0, 8'h40, 8'h00, 8'h3C, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("single_done_after_poke", 32'(actual()), 32'(modelo(0, 1'b0)));
    end
    chk("rdata_hold", 32'(rdata), 32'(8'h3C));

    // Reset during D_PUL of a read.
    iniciar(1'b0, 8'h50, 8'h00, 8'h5A);
    cuerpo(1'b0, 8'h50, 8'h00, 8'h5A, 2 * TS + TP + TH + 2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    void'(cola.pop_back());
    exp_rd = 8'h00;
    @(posedge clk); #1;
    chk("abort_pins", 32'(actual()), 32'(9'b1_0_1_1_0_0_0_0_0));
    chk("abort_rdata", 32'(rdata), 32'(0));
    reset = 1'b0;
    esperar_init();
    for (int c = 0; c < K_END + 2; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done), 32'(0));
    end
    chk("sb_drained", 32'(cola.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
